stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM that sequences the stopwatch counter datapath from debounced, edge-detected button pulses.
//  Drives the counter's enable/clear and owns the value shown on the LEDs/7-segs.
//  Captures up to LAP_DEPTH lap times into a small register file.
//  Saturates the run at MAX_SECONDS. Sits between the rising-edge detectors and the stopwatch/7-seg path.
// PARAMETERS
//  SECONDS_WIDTH  10          width of count/display/lap values
//  MAX_SECONDS    999         terminal count; run stops here (must fit SECONDS_WIDTH)
//  LAP_DEPTH      4           lap register entries
//  LAP_IDX_WIDTH  2           clog2(LAP_DEPTH)
//  HOLD_CYCLES    50000000    clk cycles the display freezes after a lap capture (>=1)
// PORTS
//  clk            in   1                clock, all state on rising edge
//  async_reset    in   1                asynchronous, active-low reset
//  start_stop     in   1                1-cycle pulse: start/pause/resume
//  lap            in   1                1-cycle pulse: capture lap
//  clear          in   1                1-cycle pulse: clear (only honoured when stopped)
//  count_value    in   SECONDS_WIDTH    current seconds from counter datapath
//  lap_rd_idx     in   LAP_IDX_WIDTH    lap register read address
//  count_enable   out  1                counter advance enable
//  count_clear    out  1                1-cycle synchronous clear to counter
//  display_value  out  SECONDS_WIDTH    value for LED/7-seg path
//  lap_rd_data    out  SECONDS_WIDTH    lap[lap_rd_idx], combinational read
//  lap_count      out  LAP_IDX_WIDTH+1  number of valid laps, 0..LAP_DEPTH
//  state_out      out  3                IDLE=0 RUN=1 LAP_HOLD=2 PAUSE=3 DONE=4
//  overflow       out  1                high while in DONE
// BEHAVIOUR
//  Reset (async_reset=0, async assert):
//  - state IDLE; all outputs 0; all lap entries 0; hold timer 0.
//  Registered outputs: every output except lap_rd_data updates on the clk edge after the causing pulse.
//  display_value in "follow" mode = count_value sampled at the previous edge (1-cycle latency).
//  Pulse priority within one cycle: clear > start_stop > lap. Losers are dropped, not queued.
//  IDLE:
//  - enable 0; display follows.
//  - start_stop -> RUN.
//  - clear -> count_clear=1 for one cycle; laps zeroed; lap_count=0; stay IDLE.
//  - lap ignored.
//  RUN:
//  - enable 1; display follows.
//  - start_stop -> PAUSE.
//  - lap -> if lap_count<LAP_DEPTH, write lap[lap_count]=count_value and increment lap_count.
//    Display frozen at the captured value; timer loaded HOLD_CYCLES-1; -> LAP_HOLD.
//    If laps are full, the lap is ignored and the state stays RUN.
//  - clear ignored.
//  LAP_HOLD:
//  - enable stays 1; display holds the captured value; timer decrements each cycle.
//  - Timer 0 -> RUN (display follows again).
//  - lap with room -> new capture, display updated, timer reloaded.
//  - lap when full -> ignored, timer not reloaded.
//  - start_stop -> PAUSE, hold abandoned.
//  - clear ignored.
//  PAUSE:
//  - enable 0; display follows (frozen counter).
//  - start_stop -> RUN.
//  - clear -> count_clear pulse, laps/lap_count zeroed, -> IDLE.
//  - lap ignored.
//  Overflow check (RUN/LAP_HOLD, highest priority over start_stop/lap):
//  - count_value>=MAX_SECONDS -> DONE; enable deasserts on that edge; overflow=1.
//  - display_value=MAX_SECONDS.
//  DONE:
//  - enable 0; display MAX_SECONDS; start_stop/lap ignored.
//  - clear -> count_clear pulse, laps zeroed, overflow=0, -> IDLE.
//  count_clear is never asserted outside the IDLE/PAUSE/DONE clear paths.
//  Reset mid-hold or mid-run returns everything to the reset state immediately; no partial lap write.
//  lap_rd_data for lap_rd_idx>=lap_count returns the stored (zero after clear) entry.
// TESTING  (HOLD_CYCLES=8, MAX_SECONDS=20 for sim)
//  1 Reset, start_stop, count_value ramps 0..5, start_stop
//    -> enable 1 the cycle after the pulse, 0 after the second; state 3; display 5.
//  2 RUN, lap at count 7 -> lap[0]=7, lap_count=1, display 7 for 8 cycles while the count advances, then follows.
//  3 Five laps at counts 2,4,6,8,10 -> lap_count=4; lap[3]=8; fifth lap ignored, state stays RUN/LAP_HOLD timing unchanged.
//  4 count_value reaches 20 in RUN -> state 4, overflow 1, enable 0, display 20; start_stop ignored;
//    clear -> count_clear 1 cycle, state 0, lap_count 0.
//  5 Same-cycle clear+start_stop in PAUSE -> clear wins (IDLE). Same-cycle start_stop+lap in RUN -> PAUSE, no lap written.
//  6 async_reset low during LAP_HOLD with lap_count=2 -> all outputs 0 immediately, lap entries 0 after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences the seconds counter from button pulses,
// owns the displayed value, and stores up to LAP_DEPTH lap times.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | stopped at zero/after clear, display follows the counter
//   RUN      | counting, display follows the counter
//   LAP_HOLD | counting, display frozen on the last captured lap
//   PAUSE    | counting suspended, display follows the frozen counter
//   DONE     | terminal count reached, display pinned to MAX_SECONDS
module stopwatch_ctrl #(
    parameter int SECONDS_WIDTH = 10,
    parameter int MAX_SECONDS   = 999,
    parameter int LAP_DEPTH     = 4,
    parameter int LAP_IDX_WIDTH = 2,
    parameter int HOLD_CYCLES   = 50000000
) (
    input  logic                     clk,
    input  logic                     async_reset,
    input  logic                     start_stop,
    input  logic                     lap,
    input  logic                     clear,
    input  logic [SECONDS_WIDTH-1:0] count_value,
    input  logic [LAP_IDX_WIDTH-1:0] lap_rd_idx,
    output logic                     count_enable,
    output logic                     count_clear,
    output logic [SECONDS_WIDTH-1:0] display_value,
    output logic [SECONDS_WIDTH-1:0] lap_rd_data,
    output logic [LAP_IDX_WIDTH:0]   lap_count,
    output logic [2:0]               state_out,
    output logic                     overflow
);

    localparam int TIMER_WIDTH = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TIMER_WIDTH-1:0]   HOLD_LOAD = TIMER_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [SECONDS_WIDTH-1:0] MAX_VAL   = SECONDS_WIDTH'(MAX_SECONDS);
    localparam logic [LAP_IDX_WIDTH:0]   LAP_FULL  = (LAP_IDX_WIDTH + 1)'(LAP_DEPTH);
    localparam logic [LAP_IDX_WIDTH:0]   LAP_ONE   = (LAP_IDX_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        LAP_HOLD = 3'd2,
        PAUSE    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [TIMER_WIDTH-1:0]   hold_timer;
    logic [TIMER_WIDTH-1:0]   timer_next;
    logic [SECONDS_WIDTH-1:0] display_next;
    logic [SECONDS_WIDTH-1:0] laps [LAP_DEPTH];
    logic                     capture;
    logic                     do_clear;
    logic                     lap_room;
    logic                     at_max;

    assign lap_room    = (lap_count < LAP_FULL);
    assign at_max      = (count_value >= MAX_VAL);
    assign lap_rd_data = laps[lap_rd_idx];
    assign state_out   = state;

    // State register.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, hold timer, lap capture/clear and display selection.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        do_clear   = 1'b0;
        timer_next = '0;
        case (state)
            IDLE: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (start_stop) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (at_max) begin
                    state_next = DONE;
                end else if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap && lap_room) begin
                    capture    = 1'b1;
                    timer_next = HOLD_LOAD;
                    state_next = LAP_HOLD;
                end
            end
            LAP_HOLD: begin
                if (at_max) begin
                    state_next = DONE;
                end else if (start_stop) begin
                    state_next = PAUSE;
                end else if (lap && lap_room) begin
                    capture    = 1'b1;
                    timer_next = HOLD_LOAD;
                end else if (hold_timer == '0) begin
                    state_next = RUN;
                end else begin
                    timer_next = hold_timer - TIMER_WIDTH'(1);
                end
            end
            PAUSE: begin
                if (clear) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end else if (start_stop) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A fresh capture shows the captured count, which is count_value itself.
        if (state_next == DONE) begin
            display_next = MAX_VAL;
        end else if (state_next == LAP_HOLD && !capture) begin
            display_next = display_value;
        end else begin
            display_next = count_value;
        end
    end

    // Registered outputs, hold timer and lap register file.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            count_enable  <= 1'b0;
            count_clear   <= 1'b0;
            overflow      <= 1'b0;
            display_value <= '0;
            hold_timer    <= '0;
            lap_count     <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                laps[i] <= '0;
            end
        end else begin
            count_enable  <= (state_next == RUN) || (state_next == LAP_HOLD);
            count_clear   <= do_clear;
            overflow      <= (state_next == DONE);
            display_value <= display_next;
            hold_timer    <= timer_next;
            if (do_clear) begin
                lap_count <= '0;
                for (int i = 0; i < LAP_DEPTH; i++) begin
                    laps[i] <= '0;
                end
            end else if (capture) begin
                laps[lap_count[LAP_IDX_WIDTH-1:0]] <= count_value;
                lap_count <= lap_count + LAP_ONE;
            end
        end
    end

endmodule
